// File: rtl/regfile_wr_arbiter.sv
// Two-requester write-port arbiter for the 32 x 32 register file. Each port has a
// one-entry holding buffer; one write per cycle, round-robin with age override.
module regfile_wr_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          en,
  input  logic          a_vld,
  input  logic [AW-1:0] a_wn,
  input  logic [DW-1:0] a_d,
  output logic          a_rdy,
  input  logic          b_vld,
  input  logic [AW-1:0] b_wn,
  input  logic [DW-1:0] b_d,
  output logic          b_rdy,
  output logic          we,
  output logic [AW-1:0] wn,
  output logic [DW-1:0] wd,
  output logic [1:0]    gnt,
  input  logic [AW-1:0] rs,
  output logic          rs_pend,
  output logic [DW-1:0] rs_fwd
);

  // Index 0 is port A, index 1 is port B throughout.
  logic [1:0]    vld_in;
  logic [AW-1:0] wn_in [2];
  logic [DW-1:0] d_in  [2];

  logic [1:0]    v_reg, v_next;
  logic [AW-1:0] wn_reg [2];
  logic [DW-1:0] d_reg  [2];
  logic          ptr_reg, ptr_next;          // 1 = favour B on contested grants
  logic          a_older_reg, a_older_next;  // 1 = A buffer was loaded first

  logic [1:0]    gnt_c;
  logic [1:0]    rdy;
  logic [1:0]    load;
  logic [1:0]    hit;
  logic          gsel;

  assign vld_in   = {b_vld, a_vld};
  assign wn_in[0] = a_wn;
  assign wn_in[1] = b_wn;
  assign d_in[0]  = a_d;
  assign d_in[1]  = b_d;

  // Arbitration; grants are suppressed while reset is asserted.
  always_comb begin
    gnt_c = 2'b00;
    if (en && clrn) begin
      case (v_reg)
        2'b01: gnt_c = 2'b01;
        2'b10: gnt_c = 2'b10;
        2'b11: begin
          if ((wn_reg[0] == wn_reg[1]) && (wn_reg[0] != '0))
            gnt_c = a_older_reg ? 2'b01 : 2'b10;
          else
            gnt_c = ptr_reg ? 2'b10 : 2'b01;
        end
        default: gnt_c = 2'b00;
      endcase
    end
  end

  // Pointer only moves when both buffers competed for the port.
  always_comb begin
    ptr_next = ptr_reg;
    if ((v_reg == 2'b11) && (gnt_c != 2'b00))
      ptr_next = gnt_c[0];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      assign rdy[gi]    = !v_reg[gi] || gnt_c[gi];
      assign load[gi]   = vld_in[gi] && rdy[gi];
      assign v_next[gi] = load[gi] || (v_reg[gi] && !gnt_c[gi]);
      assign hit[gi]    = v_reg[gi] && (wn_reg[gi] == rs) && (rs != '0);

      always_ff @(posedge clk) begin
        if (!clrn) begin
          v_reg[gi]  <= 1'b0;
          wn_reg[gi] <= '0;
          d_reg[gi]  <= '0;
        end else begin
          v_reg[gi] <= v_next[gi];
          if (load[gi]) begin
            wn_reg[gi] <= wn_in[gi];
            d_reg[gi]  <= d_in[gi];
          end
        end
      end
    end
  endgenerate

  // A newly loaded entry is younger than one that stays valid across the edge.
  always_comb begin
    a_older_next = a_older_reg;
    if (load[0] && load[1])
      a_older_next = 1'b1;
    else if (load[0] && v_next[1])
      a_older_next = 1'b0;
    else if (load[1] && v_next[0])
      a_older_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      ptr_reg     <= 1'b0;
      a_older_reg <= 1'b0;
    end else begin
      ptr_reg     <= ptr_next;
      a_older_reg <= a_older_next;
    end
  end

  assign gsel  = gnt_c[1];
  assign gnt   = gnt_c;
  assign a_rdy = rdy[0];
  assign b_rdy = rdy[1];

  always_comb begin
    we = 1'b0;
    wn = '0;
    wd = '0;
    if (gnt_c != 2'b00) begin
      wn = wn_reg[gsel];
      wd = d_reg[gsel];
      we = (wn_reg[gsel] != '0);
    end
  end

  // Forwarding returns the youngest matching entry, regardless of this cycle's grant.
  always_comb begin
    rs_pend = |hit;
    case (hit)
      2'b01:   rs_fwd = d_reg[0];
      2'b10:   rs_fwd = d_reg[1];
      2'b11:   rs_fwd = a_older_reg ? d_reg[1] : d_reg[0];
      default: rs_fwd = '0;
    endcase
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios followed by random traffic,
// all compared each cycle against a timestamp-based reference model.
module tb_regfile_wr_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clrn, en, a_vld, b_vld, a_rdy, b_rdy, we, rs_pend;
  logic [AW-1:0] a_wn, b_wn, wn, rs;
  logic [DW-1:0] a_d, b_d, wd, rs_fwd;
  logic [1:0]    gnt;

  int checks = 0;
  int errors = 0;

  // Reference model: per-port entry with the cycle number it was loaded in.
  bit            m_v  [2];
  logic [AW-1:0] m_wn [2];
  logic [DW-1:0] m_d  [2];
  int            m_ts [2];
  int            favour_b;
  int            cyc;

  regfile_wr_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .clrn(clrn), .en(en),
    .a_vld(a_vld), .a_wn(a_wn), .a_d(a_d), .a_rdy(a_rdy),
    .b_vld(b_vld), .b_wn(b_wn), .b_d(b_d), .b_rdy(b_rdy),
    .we(we), .wn(wn), .wd(wd), .gnt(gnt),
    .rs(rs), .rs_pend(rs_pend), .rs_fwd(rs_fwd)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // -1 = no grant, 0 = A, 1 = B
  function automatic int model_grant();
    if (!clrn || !en) return -1;
    if (m_v[0] && !m_v[1]) return 0;
    if (!m_v[0] && m_v[1]) return 1;
    if (!m_v[0]) return -1;
    if ((m_wn[0] == m_wn[1]) && (m_wn[0] != 0)) return (m_ts[0] <= m_ts[1]) ? 0 : 1;
    return favour_b;
  endfunction

  // Called at posedge+1; drives inputs, checks mid-cycle, then advances the model
  // and the clock together.
  task automatic step(input logic c, input logic e,
                      input logic av, input logic [AW-1:0] aw, input logic [DW-1:0] ad,
                      input logic bv, input logic [AW-1:0] bw, input logic [DW-1:0] bd,
                      input logic [AW-1:0] q, output bit a_acc, output bit b_acc);
    int g;
    bit hit [2];
    bit acc [2];
    logic [DW-1:0] e_fwd;
    clrn = c; en = e;
    a_vld = av; a_wn = aw; a_d = ad;
    b_vld = bv; b_wn = bw; b_d = bd;
    rs = q;
    #4;
    g = model_grant();
    check("gnt", 64'(gnt), (g < 0) ? 64'd0 : ((g == 0) ? 64'd1 : 64'd2));
    check("we", 64'(we), 64'((g >= 0) && (m_wn[(g < 0) ? 0 : g] != 0)));
    check("wn", 64'(wn), (g < 0) ? 64'd0 : 64'(m_wn[g]));
    check("wd", 64'(wd), (g < 0) ? 64'd0 : 64'(m_d[g]));
    check("a_rdy", 64'(a_rdy), 64'(!m_v[0] || (g == 0)));
    check("b_rdy", 64'(b_rdy), 64'(!m_v[1] || (g == 1)));
    for (int i = 0; i < 2; i++) hit[i] = m_v[i] && (m_wn[i] == q) && (q != 0);
    if (hit[0] && hit[1]) e_fwd = (m_ts[0] <= m_ts[1]) ? m_d[1] : m_d[0];
    else if (hit[0])      e_fwd = m_d[0];
    else if (hit[1])      e_fwd = m_d[1];
    else                  e_fwd = '0;
    check("rs_pend", 64'(rs_pend), 64'(hit[0] || hit[1]));
    check("rs_fwd", 64'(rs_fwd), 64'(e_fwd));
    if (g >= 0)
      $display("cycle %0d: grant %s r%0d = %08h we=%0d", cyc, (g == 0) ? "A" : "B", m_wn[g], m_d[g], m_wn[g] != 0);

    acc[0] = c && av && (!m_v[0] || (g == 0));
    acc[1] = c && bv && (!m_v[1] || (g == 1));
    if (!c) begin
      m_v[0] = 0; m_v[1] = 0; favour_b = 0;
    end else begin
      if (m_v[0] && m_v[1] && (g >= 0)) favour_b = (g == 0) ? 1 : 0;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          m_v[i] = 1; m_wn[i] = (i == 0) ? aw : bw; m_d[i] = (i == 0) ? ad : bd; m_ts[i] = cyc;
        end else if (g == i) begin
          m_v[i] = 0;
        end
      end
    end
    a_acc = acc[0];
    b_acc = acc[1];
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input logic e, input logic [AW-1:0] q, input int n);
    bit x, y;
    for (int i = 0; i < n; i++) step(1, e, 0, 0, 0, 0, 0, 0, q, x, y);
  endtask

  initial begin
    bit aa, ba;
    int ia, ib;
    m_v[0] = 0; m_v[1] = 0; m_ts[0] = 0; m_ts[1] = 0; favour_b = 0; cyc = 0;
    m_wn[0] = '0; m_wn[1] = '0; m_d[0] = '0; m_d[1] = '0;
    clrn = 0; en = 0; a_vld = 0; b_vld = 0; a_wn = 0; b_wn = 0; a_d = 0; b_d = 0; rs = 0;
    @(posedge clk); #1;
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, aa, ba);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, aa, ba);

    // single write
    step(1, 1, 1, 5, 32'h1234_5678, 0, 0, 0, 5, aa, ba);
    idle(1, 5, 2);

    // round robin, requests held until accepted
    ia = 0; ib = 0;
    for (int k = 0; k < 20 && (ia < 3 || ib < 3); k++) begin
      step(1, 1, ia < 3, AW'(1 + ia), 32'hA000 + DW'(ia), ib < 3, AW'(11 + ib), 32'hB000 + DW'(ib),
           AW'(11 + ib), aa, ba);
      if (aa) ia++;
      if (ba) ib++;
    end
    idle(1, 0, 3);

    // same-register ordering
    step(1, 1, 0, 0, 0, 1, 7, 32'hB, 7, aa, ba);
    step(1, 0, 1, 7, 32'hA, 0, 0, 0, 7, aa, ba);
    idle(1, 7, 3);

    // register 0 drop
    step(1, 1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, aa, ba);
    idle(1, 0, 2);

    // enable stall
    step(1, 1, 1, 3, 32'h3333, 1, 4, 32'h4444, 3, aa, ba);
    idle(0, 4, 3);
    idle(1, 3, 3);

    // reset mid-operation
    step(1, 1, 1, 8, 32'h8888, 1, 9, 32'h9999, 8, aa, ba);
    step(0, 1, 0, 0, 0, 0, 0, 0, 8, aa, ba);
    idle(1, 8, 1);
    step(1, 1, 1, 8, 32'h8008, 1, 9, 32'h9009, 9, aa, ba);
    idle(1, 9, 3);

    // random traffic with a narrow register range to provoke conflicts
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 99) > 1) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
           1'($urandom), AW'($urandom_range(0, 3)), DW'($urandom),
           1'($urandom), AW'($urandom_range(0, 3)), DW'($urandom),
           AW'($urandom_range(0, 3)), aa, ba);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
